// File: rtl/full_adder.sv
// Single-bit full adder: combinational sum/carry, a registered copy of them,
// and a bit-serial accumulator that keeps its carry in a register between bits.
module full_adder (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic ser_en,
    input  logic ser_start,
    output logic sum,
    output logic cout,
    output logic sum_q,
    output logic cout_q,
    output logic ser_sum,
    output logic ser_carry
);

    logic c_eff;
    logic ser_sum_nxt;
    logic ser_carry_nxt;

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

    // The first bit of a serial word takes its carry from cin; later bits
    // continue from the carry stored by the previous enabled bit.
    always_comb begin
        c_eff         = ser_start ? cin : ser_carry;
        ser_sum_nxt   = x ^ y ^ c_eff;
        ser_carry_nxt = (x & y) | (x & c_eff) | (y & c_eff);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q     <= 1'b0;
            cout_q    <= 1'b0;
            ser_sum   <= 1'b0;
            ser_carry <= 1'b0;
        end else begin
            sum_q  <= sum;
            cout_q <= cout;
            if (ser_en) begin
                ser_sum   <= ser_sum_nxt;
                ser_carry <= ser_carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed and randomized checks of full_adder against a word-level
// arithmetic model of the combinational, registered and serial paths.
`timescale 1ns/100ps
module tb_full_adder;

    logic clk;
    logic clk_run;
    logic rst_n;
    logic x;
    logic y;
    logic cin;
    logic ser_en;
    logic ser_start;
    logic sum;
    logic cout;
    logic sum_q;
    logic cout_q;
    logic ser_sum;
    logic ser_carry;

    int checks;
    int errors;

    full_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .ser_en    (ser_en),
        .ser_start (ser_start),
        .sum       (sum),
        .cout      (cout),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .ser_sum   (ser_sum),
        .ser_carry (ser_carry)
    );

    // Clock only toggles once clk_run is set, so the truth-table sweep runs clockless.
    initial begin
        clk = 1'b0;
        forever begin
            #10;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational outputs, clock once,
    // then check the registered copy of the arithmetic sum of the three bits.
    task automatic step(input logic xi, input logic yi, input logic ci,
                        input logic en, input logic st);
        int unsigned total;
        x = xi;
        y = yi;
        cin = ci;
        ser_en = en;
        ser_start = st;
        total = 32'(xi) + 32'(yi) + 32'(ci);
        #1;
        check("sum", sum, total[0]);
        check("cout", cout, total[1]);
        @(posedge clk);
        #1;
        check("sum_q", sum_q, total[0]);
        check("cout_q", cout_q, total[1]);
    endtask

    // Serial add of the low n bits of a and b, LSB first. Expected bits come
    // from the integer sum of the operand prefixes plus the initial carry.
    task automatic serial_word(input int n, input int unsigned a, input int unsigned b,
                               input logic c, input logic use_start,
                               input int pause_at, input int pause_len);
        int unsigned c0;
        int unsigned mask;
        int unsigned partial;
        logic exp_s;
        logic exp_c;
        c0 = use_start ? 32'(c) : 32'd0;
        exp_s = 1'b0;
        exp_c = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == pause_at && i > 0) begin
                for (int p = 0; p < pause_len; p++) begin
                    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
                    check("pause_ser_sum", ser_sum, exp_s);
                    check("pause_ser_carry", ser_carry, exp_c);
                end
            end
            mask = (32'd1 << (i + 1)) - 32'd1;
            partial = (a & mask) + (b & mask) + c0;
            exp_s = 1'((partial >> i) & 32'd1);
            exp_c = 1'((partial >> (i + 1)) & 32'd1);
            step(a[i], b[i], (i == 0) ? c : 1'($urandom_range(0, 1)), 1'b1,
                 (i == 0) && use_start);
            check("ser_sum", ser_sum, exp_s);
            check("ser_carry", ser_carry, exp_c);
        end
    endtask

    logic [1:0] tt_exp [8];
    logic [2:0] pat;

    initial begin
        checks = 0;
        errors = 0;
        clk_run = 1'b0;
        rst_n = 1'b0;
        x = 1'b0;
        y = 1'b0;
        cin = 1'b0;
        ser_en = 1'b0;
        ser_start = 1'b0;
        tt_exp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

        // Truth table sweep, no clock, (sum,cout) per pattern x,y,cin.
        for (int i = 0; i < 8; i++) begin
            pat = 3'(i);
            x = pat[2];
            y = pat[1];
            cin = pat[0];
            #20;
            check("tt_sum", sum, tt_exp[i][1]);
            check("tt_cout", cout, tt_exp[i][0]);
        end

        // Reset held for two edges with all data inputs high.
        x = 1'b1;
        y = 1'b1;
        cin = 1'b1;
        ser_en = 1'b1;
        ser_start = 1'b1;
        clk_run = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_sum_q", sum_q, 1'b0);
            check("rst_cout_q", cout_q, 1'b0);
            check("rst_ser_sum", ser_sum, 1'b0);
            check("rst_ser_carry", ser_carry, 1'b0);
            check("rst_sum", sum, 1'b1);
            check("rst_cout", cout, 1'b1);
        end
        rst_n = 1'b1;

        // Registered latency: 111 then 000.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1011 + 0110 with cin=0: sums 1,0,0,0 and final carry 1.
        serial_word(4, 32'b1011, 32'b0110, 1'b0, 1'b1, -1, 0);

        // Carry seed through cin on the first bit.
        serial_word(2, 32'b10, 32'b10, 1'b1, 1'b1, -1, 0);

        // Three-cycle pause mid-word.
        serial_word(6, 32'd45, 32'd27, 1'b1, 1'b1, 3, 3);

        // Reset mid-word clears the carry even with ser_en high.
        serial_word(2, 32'b11, 32'b01, 1'b0, 1'b1, -1, 0);
        rst_n = 1'b0;
        x = 1'b1;
        y = 1'b1;
        cin = 1'b1;
        ser_en = 1'b1;
        ser_start = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ser_carry", ser_carry, 1'b0);
        check("midrst_ser_sum", ser_sum, 1'b0);
        check("midrst_sum_q", sum_q, 1'b0);
        rst_n = 1'b1;

        // Next word without ser_start starts from carry 0.
        serial_word(4, 32'd5, 32'd3, 1'b1, 1'b0, -1, 0);

        // Randomized words with random pauses.
        for (int w = 0; w < 30; w++) begin
            int n;
            n = int'($urandom_range(1, 8));
            serial_word(n, $urandom_range(0, 255), $urandom_range(0, 255),
                        1'($urandom_range(0, 1)), 1'b1,
                        int'($urandom_range(1, 8)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_adder.md
# full_adder

Single-bit full adder with a combinational result path, a registered copy of that result, and a bit-serial accumulation mode that feeds the carry back through a register. It is the leaf arithmetic cell for ripple and serial adders in the datapath. The combinational outputs depend only on the data inputs. The clock and reset affect only the registered and serial outputs.

## Interface
Parameters: none.

Clocking and reset (already decided): one clock, `clk`; reset `rst_n` is synchronous and active-low.

Ports:
- clk  input  1  rising-edge clock for all registers
- rst_n  input  1  synchronous active-low reset
- x  input  1  addend bit A
- y  input  1  addend bit B
- cin  input  1  carry-in (combinational path; seeds carry in serial mode)
- ser_en  input  1  serial mode: advance one bit per clock
- ser_start  input  1  with ser_en: first bit of a word, use cin instead of stored carry
- sum  output  1  combinational x ^ y ^ cin
- cout  output  1  combinational majority(x, y, cin)
- sum_q  output  1  sum registered
- cout_q  output  1  cout registered
- ser_sum  output  1  registered serial sum bit
- ser_carry  output  1  stored serial carry register

## Operation
- Combinational path:
  - sum = x XOR y XOR cin.
  - cout = (x AND y) OR (x AND cin) OR (y AND cin).
  - Exact truth table, MSB→LSB = x,y,cin:
    - 000→s0 c0; 001→s1 c0; 010→s1 c0; 011→s0 c1
    - 100→s1 c0; 101→s0 c1; 110→s0 c1; 111→s1 c1
- Registered path: on every rising clk, sum_q <= sum and cout_q <= cout. It is unconditional and not gated by ser_en.
- Serial path:
  - c_eff = ser_start ? cin : ser_carry.
  - On a rising clk with ser_en=1: ser_sum <= x^y^c_eff and ser_carry <= majority(x,y,c_eff).
  - With ser_en=0, ser_sum and ser_carry hold.
  - ser_start is ignored when ser_en=0.
- Operand order in serial mode: LSB first, one bit pair per enabled clock. The final carry-out is ser_carry after the last bit.
- Reset (rst_n=0 at a rising clk):
  - sum_q, cout_q, ser_sum and ser_carry all go to 0.
  - Reset has priority over ser_en and ser_start.
  - sum and cout are unaffected by reset.
- X/Z on any input propagates; no sanitising.

## Timing
- sum and cout have zero-cycle latency and are purely combinational. They must settle well inside a 20 ns stimulus step (timescale 1 ns/100 ps).
- sum_q and cout_q have 1-cycle latency after the clk edge that samples the inputs.
- ser_sum and ser_carry update one clk edge after each enabled bit. An N-bit serial add takes N enabled cycles; the result carry is valid after the Nth edge.
- Reset mid-operation: a serial word in progress is abandoned and the carry is cleared. The next word must assert ser_start, or it starts with carry 0.
- ser_en deasserted mid-word pauses the add losslessly; the next enabled bit continues from the stored carry.

## Test plan
- Truth-table sweep with no clock running, one step every 20 ns, (x,y,cin) driven in this order:
  - 000, 001, 010, 011, 100, 101, 110, 111
  - Required (sum,cout): 00, 10, 10, 01, 10, 01, 01, 11.
- Registered latency: apply x=1,y=1,cin=1 just before edge k → sum_q=1, cout_q=1 after edge k. Change to 000 → both 0 after edge k+1.
- Reset: hold rst_n=0 for 2 edges with x=y=cin=1 → sum_q, cout_q, ser_sum and ser_carry all 0; sum=1 and cout=1 throughout.
- Serial add 1011+0110, LSB first, cin=0, ser_start on the first bit:
  - ser_sum sequence 1,0,0,0.
  - Final ser_carry=1 (result 17).
- Serial with carry seed: cin=1, ser_start, x=0, y=0 → ser_sum=1, ser_carry=0. Next enabled bit x=1,y=1 → ser_sum=0, ser_carry=1.
- Pause and reset mid-word:
  - ser_en=0 for 3 cycles mid-word → outputs hold.
  - rst_n=0 mid-word → ser_carry=0 on the next edge.
